lcd_ctrl: RTL

- Sits directly downstream of the LSU's LCD output register (0x7030), between that register and the HD44780-compatible character LCD pins.
- Turns each software-issued command or data transfer into a correctly timed bus cycle: RS/RW setup, E pulse, hold, then an execution wait.
- Returns a status word (busy flag and read-back byte) for the LSU input space at 0x7820, so firmware polls instead of software-timing delays.

---
 rtl/lcd_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/lcd_ctrl.sv
// HD44780 bus sequencer: turns a START edge on the LSU LCD register into a
// timed setup / E pulse / hold / execution-wait cycle and reports busy + read-back.
`timescale 1ns/1ps
module lcd_ctrl #(
  parameter int unsigned T_SETUP_CYC = 4,
  parameter int unsigned T_EN_CYC    = 12,
  parameter int unsigned T_HOLD_CYC  = 2,
  parameter int unsigned T_EXEC_CYC  = 2000,
  parameter int unsigned T_LONG_CYC  = 82000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_io_lcd,
  input  logic [7:0]  i_lcd_data,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_data_oe,
  output logic        o_lcd_en,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_on,
  output logic [31:0] o_lcd_status
);

  localparam int unsigned P_MAX01 = (T_SETUP_CYC > T_EN_CYC)   ? T_SETUP_CYC : T_EN_CYC;
  localparam int unsigned P_MAX2  = (P_MAX01 > T_HOLD_CYC)     ? P_MAX01     : T_HOLD_CYC;
  localparam int unsigned P_MAX3  = (P_MAX2 > T_EXEC_CYC)      ? P_MAX2      : T_EXEC_CYC;
  localparam int unsigned P_MAX   = (P_MAX3 > T_LONG_CYC)      ? P_MAX3      : T_LONG_CYC;
  localparam int unsigned CW      = (P_MAX > 1) ? $clog2(P_MAX) : 1;

  localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP_CYC - 1);
  localparam logic [CW-1:0] LD_EN    = CW'(T_EN_CYC - 1);
  localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD_CYC - 1);
  localparam logic [CW-1:0] LD_EXEC  = CW'(T_EXEC_CYC - 1);
  localparam logic [CW-1:0] LD_LONG  = CW'(T_LONG_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ENABLE, S_HOLD, S_EXEC} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_start_q;
  logic            r_rs, r_rw, r_on, r_rd_valid;
  logic [7:0]      r_dat, r_rd_data;

  logic            w_start, w_accept, w_cnt_zero, w_long_cmd, w_drive, w_capture;
  logic            w_unused;

  assign w_start    = i_io_lcd[10] & ~r_start_q;
  assign w_accept   = (r_state == S_IDLE) & w_start;
  assign w_cnt_zero = (r_cnt == '0);
  // Clear display / return home need the long execution wait.
  assign w_long_cmd = ~r_rs & ~r_rw & ((r_dat == 8'h01) | (r_dat == 8'h02) | (r_dat == 8'h03));
  assign w_capture  = (r_state == S_ENABLE) & w_cnt_zero & r_rw;
  assign w_unused   = &{1'b0, i_io_lcd[30:11]};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_cnt_zero ? r_cnt : r_cnt - CW'(1);
    case (r_state)
      S_IDLE: if (w_start) begin
        w_state_nxt = S_SETUP;
        w_cnt_nxt   = LD_SETUP;
      end
      S_SETUP: if (w_cnt_zero) begin
        w_state_nxt = S_ENABLE;
        w_cnt_nxt   = LD_EN;
      end
      S_ENABLE: if (w_cnt_zero) begin
        w_state_nxt = S_HOLD;
        w_cnt_nxt   = LD_HOLD;
      end
      S_HOLD: if (w_cnt_zero) begin
        if (r_rw) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_EXEC;
          w_cnt_nxt   = w_long_cmd ? LD_LONG : LD_EXEC;
        end
      end
      S_EXEC: if (w_cnt_zero) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_start_q  <= 1'b1;
      r_rs       <= 1'b0;
      r_rw       <= 1'b0;
      r_dat      <= '0;
      r_on       <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_start_q <= i_io_lcd[10];
      r_on      <= i_io_lcd[31];
      if (w_accept) begin
        r_rs       <= i_io_lcd[9];
        r_rw       <= i_io_lcd[8];
        r_dat      <= i_io_lcd[7:0];
        r_rd_valid <= 1'b0;
        r_rd_data  <= '0;
      end else if (w_capture) begin
        r_rd_valid <= 1'b1;
        r_rd_data  <= i_lcd_data;
      end
    end
  end

  assign w_drive       = (r_state == S_SETUP) | (r_state == S_ENABLE) | (r_state == S_HOLD);
  assign o_lcd_en      = (r_state == S_ENABLE);
  assign o_lcd_rs      = w_drive & r_rs;
  assign o_lcd_rw      = w_drive & r_rw;
  assign o_lcd_data    = w_drive ? r_dat : '0;
  assign o_lcd_data_oe = w_drive & ~r_rw;
  assign o_lcd_on      = r_on;
  assign o_lcd_status  = {(r_state != S_IDLE), 22'd0, r_rd_valid, r_rd_data};

endmodule
